// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers and a start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iFlush,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivByZero,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

  stateT            state;
  logic [CNT_W-1:0] counter;

  logic [WIDTH-1:0] magA, magB, aOrig, accHi, accLo;
  logic             isDiv, negLo, negHi, divZero;

  logic signed [WIDTH-1:0] aSgn, bSgn;
  logic [WIDTH-1:0]        inMagA, inMagB;
  logic                    opSigned, load, fastMul;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v, input logic isSigned);
    return (isSigned && v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (WIDTH'(0) - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] condNegWide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? ((2*WIDTH)'(0) - v) : v;
  endfunction

  assign aSgn     = iA;
  assign bSgn     = iB;
  assign opSigned = ~iOp[0];
  assign inMagA   = magnitude(aSgn, opSigned);
  assign inMagB   = magnitude(bSgn, opSigned);
  assign load     = (state == IDLE) && iStart && !iFlush && !iOp[2];
`ifdef MULDIV_FAST_MUL_EN
  assign fastMul  = ~iOp[1];
`else
  assign fastMul  = 1'b0;
`endif

  // One radix-2 step: shift-add multiply (multiplier in accLo) or restoring divide (dividend in accLo).
  logic [WIDTH:0]   mulSum, divShift;
  logic             divGe;
  logic [WIDTH-1:0] stepHi, stepLo;

  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, magA} : {(WIDTH+1){1'b0}});
    divShift = {accHi, accLo[WIDTH-1]};
    divGe    = divShift >= {1'b0, magB};
    stepHi   = mulSum[WIDTH:1];
    stepLo   = {mulSum[0], accLo[WIDTH-1:1]};
    if (isDiv) begin
      stepHi = divGe ? (divShift[WIDTH-1:0] - magB) : divShift[WIDTH-1:0];
      stepLo = {accLo[WIDTH-2:0], divGe};
    end
  end

  // Final sign correction of the magnitude result.
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   resHi, resLo;

  always_comb begin
    prodFix = condNegWide({accHi, accLo}, negLo);
    resHi   = prodFix[2*WIDTH-1:WIDTH];
    resLo   = prodFix[WIDTH-1:0];
    if (isDiv) begin
      resHi = divZero ? aOrig : condNeg(accHi, negHi);
      resLo = divZero ? {WIDTH{1'b1}} : condNeg(accLo, negLo);
    end
  end

  always_ff @(posedge iCLK) begin
    if (load) begin
      magA    <= inMagA;
      magB    <= inMagB;
      aOrig   <= iA;
      isDiv   <= iOp[1];
      negLo   <= opSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
      negHi   <= opSigned & iA[WIDTH-1];
      divZero <= (iB == '0);
      accHi   <= '0;
      if (iOp[1]) begin
        accLo <= inMagA;
      end else begin
`ifdef MULDIV_FAST_MUL_EN
        {accHi, accLo} <= {{WIDTH{1'b0}}, inMagA} * {{WIDTH{1'b0}}, inMagB};
`else
        accLo <= inMagB;
`endif
      end
    end else if (state == RUN) begin
      accHi <= stepHi;
      accLo <= stepLo;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state      <= IDLE;
      counter    <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oDivByZero <= 1'b0;
      oHI        <= '0;
      oLO        <= '0;
    end else begin
      oDone      <= 1'b0;
      oDivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            oBusy <= 1'b1;
            if (fastMul) begin
              state   <= FIX;
              counter <= '0;
            end else begin
              state   <= RUN;
              counter <= CNT_W'(WIDTH);
            end
          end else if (iStart && !iFlush && iOp == OP_MTHI) begin
            oHI <= iA;
          end else if (iStart && !iFlush && iOp == OP_MTLO) begin
            oLO <= iA;
          end
        end
        RUN: begin
          if (iFlush) begin
            state   <= IDLE;
            oBusy   <= 1'b0;
            counter <= '0;
          end else begin
            counter <= counter - 1'b1;
            if (counter == CNT_W'(1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          oBusy <= 1'b0;
          if (!iFlush) begin
            oHI        <= resHi;
            oLO        <= resLo;
            oDone      <= 1'b1;
            oDivByZero <= isDiv & divZero;
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH=32.
module tb_mul_div_unit;

  localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = WIDTH + 1;
`endif
  localparam int DIV_LAT = WIDTH + 1;

  logic             iCLK, iRST, iStart, iFlush;
  logic [2:0]       iOp;
  logic [WIDTH-1:0] iA, iB;
  logic             oBusy, oDone, oDivByZero;
  logic [WIDTH-1:0] oHI, oLO;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
    .iFlush(iFlush), .oBusy(oBusy), .oDone(oDone), .oDivByZero(oDivByZero),
    .oHI(oHI), .oLO(oLO)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic startOp(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    iStart = 1'b1;
    iOp    = op;
    iA     = a;
    iB     = b;
    tick();
    iStart = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int expLat, input int n0);
    int n;
    n = n0;
    while (!oDone && n < 100) begin
      tick();
      n++;
    end
    checkVal({tag, " latency"}, n, expLat);
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input int lat, input logic [WIDTH-1:0] expHi,
                       input logic [WIDTH-1:0] expLo, input logic expDz);
    startOp(op, a, b);
    checkVal({tag, " busy"}, oBusy, 1);
    waitDone(tag, lat, 0);
    checkVal({tag, " hi"}, oHI, expHi);
    checkVal({tag, " lo"}, oLO, expLo);
    checkVal({tag, " dz"}, oDivByZero, expDz);
    checkVal({tag, " busy end"}, oBusy, 0);
    tick();
    checkVal({tag, " done pulse"}, oDone, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d;
    iRST = 1'b0; iStart = 1'b0; iFlush = 1'b0; iOp = '0; iA = '0; iB = '0;
    repeat (3) tick();
    checkVal("rst hi", oHI, 0);
    checkVal("rst lo", oLO, 0);
    checkVal("rst busy", oBusy, 0);
    checkVal("rst done", oDone, 0);
    checkVal("rst dz", oDivByZero, 0);
    iRST = 1'b1;
    tick();

    runOp("mult", 3'd0, 32'hFFFFFFFD, 32'd7, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    runOp("divu", 3'd3, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b0);
    runOp("div", 3'd2, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runOp("div ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h0, 32'h80000000, 1'b0);
    runOp("divu zero", 3'd3, 32'd5, 32'd0, DIV_LAT, 32'd5, 32'hFFFFFFFF, 1'b1);
    runOp("div zero", 3'd2, 32'hFFFFFFFB, 32'd0, DIV_LAT, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    runOp("multu max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001, 1'b0);

    // Back-to-back MTHI / MTLO.
    iStart = 1'b1; iOp = 3'd4; iA = 32'h12345678;
    tick();
    checkVal("mthi hi", oHI, 32'h12345678);
    checkVal("mthi lo", oLO, 32'h00000001);
    checkVal("mthi busy", oBusy, 0);
    iOp = 3'd5; iA = 32'h9ABCDEF0;
    tick();
    iStart = 1'b0;
    checkVal("mtlo lo", oLO, 32'h9ABCDEF0);
    checkVal("mtlo hi", oHI, 32'h12345678);
    checkVal("mtlo busy", oBusy, 0);
    checkVal("mtlo done", oDone, 0);

    // MTHI while a MULT is in flight is dropped.
    startOp(3'd0, 32'd3, 32'd5);
    iStart = 1'b1; iOp = 3'd4; iA = 32'h0000DEAD;
    tick();
    iStart = 1'b0;
    waitDone("mult+mthi", MUL_LAT, 1);
    checkVal("mult+mthi hi", oHI, 32'h0);
    checkVal("mult+mthi lo", oLO, 32'd15);
    tick();

    // Flush a DIV mid-flight.
    startOp(3'd2, 32'd1000, 32'd3);
    repeat (9) tick();
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
    checkVal("flush busy", oBusy, 0);
    checkVal("flush done", oDone, 0);
    d = 0;
    repeat (40) begin
      tick();
      if (oDone) d++;
    end
    checkVal("flush no done", d, 0);
    checkVal("flush hi", oHI, 32'h0);
    checkVal("flush lo", oLO, 32'd15);

    // Flush in IDLE suppresses a simultaneous MTHI.
    iFlush = 1'b1; iStart = 1'b1; iOp = 3'd4; iA = 32'd77;
    tick();
    iFlush = 1'b0; iStart = 1'b0;
    checkVal("idle flush hi", oHI, 32'h0);

    // New start accepted in the oDone cycle.
    startOp(3'd3, 32'd100, 32'd7);
    waitDone("divu chain", DIV_LAT, 0);
    iStart = 1'b1; iOp = 3'd1; iA = 32'd6; iB = 32'd7;
    tick();
    iStart = 1'b0;
    checkVal("chain busy", oBusy, 1);
    checkVal("chain done low", oDone, 0);
    checkVal("chain hi hold", oHI, 32'd2);
    checkVal("chain lo hold", oLO, 32'd14);
    waitDone("multu chain", MUL_LAT, 0);
    checkVal("chain hi", oHI, 32'h0);
    checkVal("chain lo", oLO, 32'd42);
    tick();

    // Asynchronous reset during a DIV.
    startOp(3'd2, 32'd1000, 32'd3);
    repeat (14) tick();
    #2;
    iRST = 1'b0;
    #1;
    checkVal("async rst hi", oHI, 32'h0);
    checkVal("async rst lo", oLO, 32'h0);
    checkVal("async rst busy", oBusy, 0);
    tick();
    tick();
    iRST = 1'b1;
    tick();
    runOp("multu post rst", 3'd1, 32'hFFFFFFFF, 32'd2, MUL_LAT, 32'h1, 32'hFFFFFFFE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
